nrzi: RTL and testbench

- Serial NRZI (Non-Return-to-Zero Inverted) line encoder.
- Converts an NRZ bit stream `x`, one bit per clock, into a line level `z`.
- A logic-1 input toggles the line; a logic-0 input holds it.
- Sits between the serializer and the line driver/pad. Single clock domain, registered output.

---
 rtl/nrzi.sv | 28 ++
 tb/tb_nrzi.sv | 115 +++++++++++
 2 files changed

// File: rtl/nrzi.sv
// nrzi: serial NRZI line encoder, one independent flop per lane.
//   clock : rising-edge clock, one data bit per lane per cycle
//   reset : asynchronous active-low reset, forces z to INIT_LEVEL on every lane
//   x     : [WIDTH-1:0] NRZ data in
//   z     : [WIDTH-1:0] NRZI line level, straight from the state flops
// Build option NRZI_INVERT_EN selects the NRZI-S convention (0 toggles, 1 holds).
module nrzi #(
  parameter int   WIDTH      = 1,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] z
);
  logic [WIDTH-1:0] z_q, z_d;
  always_comb begin
`ifdef NRZI_INVERT_EN
    z_d = z_q ^ ~x;
`else
    z_d = z_q ^ x;
`endif
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) z_q <= {WIDTH{INIT_LEVEL}};
    else        z_q <= z_d;
  assign z = z_q;
endmodule

// File: tb/tb_nrzi.sv
// tb_nrzi: randomized scoreboard bench for nrzi, lane-level toggle-count model.
module tb_nrzi;
  localparam int   W    = 4;
  localparam logic INIT = 1'b0;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] x = '0, z;
  int           errors = 0, checks = 0;
  logic [W-1:0] q[$];
  int unsigned  toggles[W];

  nrzi #(.WIDTH(W), .INIT_LEVEL(INIT)) dut (.clock(clk), .reset(rst_n), .x(x), .z(z));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] level();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = INIT ^ toggles[i][0];
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: z=%b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < W; i++) toggles[i] = 0;
  endtask

  task automatic send(input logic [W-1:0] v);
    @(negedge clk);
    x = v;
    for (int i = 0; i < W; i++)
`ifdef NRZI_INVERT_EN
      if (!v[i]) toggles[i]++;
`else
      if (v[i]) toggles[i]++;
`endif
    q.push_back(level());
  endtask

  task automatic stream(input logic [15:0] s, input int nbits);
    logic [W-1:0] v;
    for (int b = 15; b > 15 - nbits; b--) begin
      v = W'($urandom);
      v[0] = s[b];
      send(v);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && q.size() > 0; n++) begin
      @(posedge clk);
      #3;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d outputs pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", z, {W{INIT}});
    x = '0;
    clear_model();
    #1 rst_n = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (q.size() > 0) check("stream", z, q.pop_front());
  end

  initial begin
    clear_model();
    repeat (6) begin
      @(negedge clk);
      check("reset_hold", z, {W{INIT}});
      x = W'($urandom);
    end
    @(negedge clk);
    x = '0;
    rst_n = 1'b1;
    stream(16'hF161, 16);
    drain();
    pulse_reset();
    stream(16'hCF0C, 16);
    drain();
    pulse_reset();
    stream(16'h8C00, 16);
    drain();
    pulse_reset();
    stream(16'hF161, 5);
    drain();
    pulse_reset();
    send(W'(1));
    send(W'(1));
    drain();
    send('1);
    drain();
    pulse_reset();
    repeat (200) send(W'($urandom));
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
